// File: rtl/aes_pkg.sv
// Shared AES key-schedule types and constants: word/round-key types, FSM states, Rcon, GF(2^8) helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] rkey_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXPAND,
        ST_DRAIN
    } state_t;

    // Only the three AES key sizes are meaningful.
    function automatic bit key_bits_legal(input int kb);
        return (kb == 128) || (kb == 192) || (kb == 256);
    endfunction

    // Round constant high byte; index 1..10, anything else yields 0.
    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Start/key request and round-key stream between the key expander and the round pipeline.
// Latency: n/a (wires only).
// Backpressure: rk_ready from the consumer stalls the round-key stream.
interface aes_key_expander_if #(parameter int KEY_BITS = 128);
    import aes_pkg::*;

    logic                start;
    logic                start_ready;
    logic [KEY_BITS-1:0] key_in;
    logic                rk_valid;
    logic                rk_ready;
    rkey_t               rk_data;
    logic [3:0]          rk_idx;
    logic                rk_last;

    modport master (
        output start, key_in, rk_ready,
        input  start_ready, rk_valid, rk_data, rk_idx, rk_last
    );

    modport slave (
        input  start, key_in, rk_ready,
        output start_ready, rk_valid, rk_data, rk_idx, rk_last
    );
endinterface

// File: rtl/aes_sub_word.sv
// SubWord: four AES S-boxes applied bytewise; the only S-box logic in the key expander.
// Latency: combinational.
// Backpressure: none.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

    // Multiplicative inverse as a^254 (0 maps to 0), then the AES affine transform.
    always_comb begin
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
        s    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_sub_word
    import aes_pkg::*;
(
    input  word_t din,
    output word_t dout
);
    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (.a(din[8*b +: 8]), .s(dout[8*b +: 8]));
    end
endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES key schedule: one 32-bit word per cycle, packed into 128-bit round keys (AES_KEYEXP_STORE_EN adds a readable round-key store).
// Latency: round key r valid 4r+4 cycles after start accept; one word per cycle thereafter.
// Backpressure: word generation stalls when the 4th word of a round key is due and rk_data is still held.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
)
(
    input  logic                 clk,
    input  logic                 rst,
    aes_key_expander_if.slave    kx,
    output logic                 busy
`ifdef AES_KEYEXP_STORE_EN
    ,
    input  logic [3:0]           rd_idx,
    output rkey_t                rd_data,
    output logic                 store_valid
`endif
);
    localparam int          NK      = KEY_BITS / 32;
    localparam int          NR      = NK + 6;
    localparam logic [5:0]  LAST_W  = 6'(4 * (NR + 1) - 1);
    localparam logic [3:0]  NR_L    = 4'(NR);
    localparam logic [2:0]  NK_LAST = 3'(NK - 1);

    if (!key_bits_legal(KEY_BITS)) begin : g_bad_key_bits
        $error("aes_key_expander: KEY_BITS must be 128, 192 or 256");
    end

    state_t      state;
    logic [5:0]  wcnt;      // word index i of the next word to produce
    logic [2:0]  phase;     // i mod NK
    logic [3:0]  rc_idx;    // i / NK for the next rotate-and-substitute word
    word_t       win [NK];  // win[0] = w[i-NK] ... win[NK-1] = w[i-1]
    logic [95:0] asm_q;     // first three words of the round key being assembled
    logic [1:0]  asm_cnt;   // words already in asm_q
    logic [3:0]  rnd;       // round keys transferred so far this run

    word_t temp, sw_in, sw_out, load_word, exp_word, cur_word;
    logic  active, out_free, gen_en, xfer, start_acc, last_acc;

    assign kx.start_ready = (state == ST_IDLE);
    assign busy           = (state != ST_IDLE);
    assign start_acc      = kx.start && kx.start_ready;
    assign active         = (state == ST_LOAD) || (state == ST_EXPAND);
    assign out_free       = !kx.rk_valid || kx.rk_ready;
    // The 4th word of a round key goes straight to rk_data, so it may only be
    // produced when the output register is free; this is the stall point.
    assign gen_en         = active && ((asm_cnt != 2'd3) || out_free);
    assign xfer           = gen_en && (asm_cnt == 2'd3);
    assign last_acc       = kx.rk_valid && kx.rk_ready && kx.rk_last;

    aes_sub_word u_sub (.din(sw_in), .dout(sw_out));

    // Next schedule word: key words during LOAD, recurrence during EXPAND.
    always_comb begin
        temp      = win[NK-1];
        sw_in     = (phase == 3'd0) ? {temp[23:0], temp[31:24]} : temp;
        load_word = '0;
        for (int k = 0; k < NK; k++) begin
            if (phase == 3'(k)) load_word = win[k];
        end
        if (phase == 3'd0)
            exp_word = win[0] ^ sw_out ^ {rcon(rc_idx), 24'h0};
        else if ((NK == 8) && (phase == 3'd4))
            exp_word = win[0] ^ sw_out;
        else
            exp_word = win[0] ^ temp;
        cur_word = (state == ST_LOAD) ? load_word : exp_word;
    end

    // Control FSM, key window, round-key assembly and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            wcnt        <= '0;
            phase       <= '0;
            rc_idx      <= 4'd1;
            asm_q       <= '0;
            asm_cnt     <= '0;
            rnd         <= '0;
            kx.rk_valid <= 1'b0;
            kx.rk_data  <= '0;
            kx.rk_idx   <= '0;
            kx.rk_last  <= 1'b0;
            for (int k = 0; k < NK; k++) win[k] <= '0;
        end else begin
            if (xfer) begin
                kx.rk_valid <= 1'b1;
                kx.rk_data  <= {asm_q, cur_word};
                kx.rk_idx   <= rnd;
                kx.rk_last  <= (rnd == NR_L);
                rnd         <= rnd + 4'd1;
            end else if (kx.rk_ready) begin
                kx.rk_valid <= 1'b0;
            end

            if (gen_en) begin
                asm_q   <= {asm_q[63:0], cur_word};
                asm_cnt <= asm_cnt + 2'd1;
                wcnt    <= wcnt + 6'd1;
                phase   <= (phase == NK_LAST) ? 3'd0 : phase + 3'd1;
                if (state == ST_EXPAND) begin
                    for (int k = 0; k < NK - 1; k++) win[k] <= win[k+1];
                    win[NK-1] <= cur_word;
                    if (phase == 3'd0) rc_idx <= rc_idx + 4'd1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start_acc) begin
                        state   <= ST_LOAD;
                        wcnt    <= '0;
                        phase   <= '0;
                        rc_idx  <= 4'd1;
                        asm_cnt <= '0;
                        rnd     <= '0;
                        for (int k = 0; k < NK; k++)
                            win[k] <= kx.key_in[KEY_BITS-1-32*k -: 32];
                    end
                end
                ST_LOAD:   if (gen_en && (phase == NK_LAST)) state <= ST_EXPAND;
                ST_EXPAND: if (gen_en && (wcnt == LAST_W))   state <= ST_DRAIN;
                ST_DRAIN:  if (last_acc)                     state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

`ifdef AES_KEYEXP_STORE_EN
    rkey_t store [NR+1];

    // Capture every round key as it enters rk_data; registered random read.
    always_ff @(posedge clk) begin
        if (xfer) store[rnd] <= {asm_q, cur_word};
        if (rst) begin
            rd_data     <= '0;
            store_valid <= 1'b0;
        end else begin
            rd_data <= (rd_idx <= NR_L) ? store[rd_idx] : '0;
            if (start_acc)     store_valid <= 1'b0;
            else if (last_acc) store_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed check of aes_key_expander for 128/192/256-bit keys against FIPS-197 round keys.
// Latency: measures round-key timing and drain timing against the cycle counts of the design.
// Backpressure: one run with random rk_ready, checking hold stability and index ordering.
module tb_aes_key_expander;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_key_expander_if #(.KEY_BITS(128)) if128 ();
    aes_key_expander_if #(.KEY_BITS(192)) if192 ();
    aes_key_expander_if #(.KEY_BITS(256)) if256 ();
    logic busy0, busy1, busy2;
`ifdef AES_KEYEXP_STORE_EN
    logic [3:0] rd_idx0, rd_idx1, rd_idx2;
    rkey_t      rd_data0, rd_data1, rd_data2;
    logic       sv0, sv1, sv2;
`endif

    aes_key_expander #(.KEY_BITS(128)) dut128 (
        .clk(clk), .rst(rst), .kx(if128), .busy(busy0)
`ifdef AES_KEYEXP_STORE_EN
        , .rd_idx(rd_idx0), .rd_data(rd_data0), .store_valid(sv0)
`endif
    );
    aes_key_expander #(.KEY_BITS(192)) dut192 (
        .clk(clk), .rst(rst), .kx(if192), .busy(busy1)
`ifdef AES_KEYEXP_STORE_EN
        , .rd_idx(rd_idx1), .rd_data(rd_data1), .store_valid(sv1)
`endif
    );
    aes_key_expander #(.KEY_BITS(256)) dut256 (
        .clk(clk), .rst(rst), .kx(if256), .busy(busy2)
`ifdef AES_KEYEXP_STORE_EN
        , .rd_idx(rd_idx2), .rd_data(rd_data2), .store_valid(sv2)
`endif
    );

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    typedef struct {
        int          k;      // 0: AES-128, 1: AES-192, 2: AES-256
        int          idx;    // round number
        logic [127:0] exp;   // expected round key
        logic        last;   // expected rk_last
    } vec_t;
    vec_t tab [10];

    // Per-instance capture of accepted round keys.
    rkey_t      cap   [3][16];
    logic       capl  [3][16];
    int         first [3][16];
    int         nacc  [3];
    int         acc_cyc [3];
    logic       held  [3];
    rkey_t      hd    [3];
    logic [3:0] hi    [3];
    logic       hl    [3];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic mon(input int k, input logic v, input logic r, input rkey_t d,
                       input logic [3:0] idx, input logic l);
        if (held[k]) begin
            check($sformatf("stall_valid inst%0d", k), 128'(v), 128'd1);
            check($sformatf("stall_data inst%0d", k), d, hd[k]);
            check($sformatf("stall_idx_last inst%0d", k), 128'({idx, l}), 128'({hi[k], hl[k]}));
        end
        if (v) begin
            if (first[k][idx] < 0) first[k][idx] = cyc - acc_cyc[k];
            if (r) begin
                check($sformatf("order inst%0d", k), 128'(idx), 128'(nacc[k]));
                cap[k][idx]  = d;
                capl[k][idx] = l;
                nacc[k]++;
            end
        end
        held[k] = v && !r;
        hd[k]   = d;
        hi[k]   = idx;
        hl[k]   = l;
    endtask

    always @(negedge clk) begin
        mon(0, if128.rk_valid, if128.rk_ready, if128.rk_data, if128.rk_idx, if128.rk_last);
        mon(1, if192.rk_valid, if192.rk_ready, if192.rk_data, if192.rk_idx, if192.rk_last);
        mon(2, if256.rk_valid, if256.rk_ready, if256.rk_data, if256.rk_idx, if256.rk_last);
    end

    function automatic logic get_busy(input int k);
        case (k)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic get_sr(input int k);
        case (k)
            0:       return if128.start_ready;
            1:       return if192.start_ready;
            default: return if256.start_ready;
        endcase
    endfunction

    function automatic logic get_vld(input int k);
        case (k)
            0:       return if128.rk_valid;
            1:       return if192.rk_valid;
            default: return if256.rk_valid;
        endcase
    endfunction

    task automatic set_start(input int k, input logic s, input logic [255:0] key);
        case (k)
            0:       begin if128.start = s; if128.key_in = key[255:128]; end
            1:       begin if192.start = s; if192.key_in = key[255:64];  end
            default: begin if256.start = s; if256.key_in = key;          end
        endcase
    endtask

    task automatic set_rdy(input int k, input logic r);
        case (k)
            0:       if128.rk_ready = r;
            1:       if192.rk_ready = r;
            default: if256.rk_ready = r;
        endcase
    endtask

    task automatic clear(input int k);
        nacc[k] = 0;
        held[k] = 1'b0;
        for (int j = 0; j < 16; j++) begin
            first[k][j] = -1;
            cap[k][j]   = '0;
            capl[k][j]  = 1'b0;
        end
    endtask

    // Present start for one cycle; returns one cycle after the accepting edge.
    task automatic kick(input int k, input logic [255:0] key);
        int n;
        n = 0;
        clear(k);
        while (!get_sr(k) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("start_ready inst%0d", k), 128'(get_sr(k)), 128'd1);
        set_start(k, 1'b1, key);
        acc_cyc[k] = cyc + 1;
        @(posedge clk); #1;
        set_start(k, 1'b0, key);
    endtask

    // Run until busy drops; optional random rk_ready and a start pulse while busy.
    task automatic wait_done(input int k, input bit bp, input int poke, input int budget,
                             output int took);
        int n;
        n = 0;
        while (get_busy(k) && n < budget) begin
            @(posedge clk); #1;
            n++;
            set_rdy(k, bp ? 1'($urandom_range(0, 1)) : 1'b1);
            if (poke != 0 && n == poke)     set_start(k, 1'b1, '1);
            if (poke != 0 && n == poke + 1) set_start(k, 1'b0, '1);
        end
        took = cyc - acc_cyc[k];
        check($sformatf("done_in_budget inst%0d", k), 128'(get_busy(k)), 128'd0);
        set_rdy(k, 1'b1);
    endtask

    task automatic check_table(input int only_k);
        for (int j = 0; j < 10; j++) begin
            if (only_k < 0 || tab[j].k == only_k) begin
                check($sformatf("rk inst%0d idx%0d", tab[j].k, tab[j].idx),
                      cap[tab[j].k][tab[j].idx], tab[j].exp);
                check($sformatf("last inst%0d idx%0d", tab[j].k, tab[j].idx),
                      128'(capl[tab[j].k][tab[j].idx]), 128'(tab[j].last));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int took;

        tab[0] = '{0, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0};
        tab[1] = '{0, 1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b0};
        tab[2] = '{0, 2,  128'hf2c295f27a96b9435935807a7359f67f, 1'b0};
        tab[3] = '{0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1};
        tab[4] = '{1, 0,  128'h8e73b0f7da0e6452c810f32b809079e5, 1'b0};
        tab[5] = '{1, 1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5, 1'b0};
        tab[6] = '{1, 12, 128'he98ba06f448c773c8ecc720401002202, 1'b1};
        tab[7] = '{2, 0,  128'h603deb1015ca71be2b73aef0857d7781, 1'b0};
        tab[8] = '{2, 1,  128'h1f352c073b6108d72d9810a30914dff4, 1'b0};
        tab[9] = '{2, 14, 128'hfe4890d1e6188d0b046df344706c631e, 1'b1};

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_start(k, 1'b0, '0);
            set_rdy(k, 1'b1);
            clear(k);
            acc_cyc[k] = 0;
        end
`ifdef AES_KEYEXP_STORE_EN
        rd_idx0 = 4'd0; rd_idx1 = 4'd0; rd_idx2 = 4'd0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset rk_valid",    128'(if128.rk_valid), 128'd0);
        check("reset rk_data",     if128.rk_data, 128'd0);
        check("reset rk_idx",      128'(if128.rk_idx), 128'd0);
        check("reset rk_last",     128'(if128.rk_last), 128'd0);
        check("reset busy",        128'(busy0), 128'd0);
        check("reset start_ready", 128'(if128.start_ready), 128'd1);
        rst = 1'b0;

        // AES-128, no backpressure.
        kick(0, KEY128);
        wait_done(0, 1'b0, 0, 200, took);
        check("drain128 cycles",     128'(took), 128'd45);
        check("drain128 rk_valid",   128'(get_vld(0)), 128'd0);
        check("drain128 start_rdy",  128'(get_sr(0)), 128'd1);
        check("count128",            128'(nacc[0]), 128'd11);
        check("lat128 rk0",          128'(first[0][0]), 128'd4);
        check("lat128 rk1",          128'(first[0][1]), 128'd8);
        check("lat128 rk10",         128'(first[0][10]), 128'd44);

        // AES-192 and AES-256, no backpressure.
        kick(1, KEY192);
        wait_done(1, 1'b0, 0, 200, took);
        check("drain192 cycles",     128'(took), 128'd53);
        check("count192",            128'(nacc[1]), 128'd13);
        check("lat192 rk12",         128'(first[1][12]), 128'd52);
        kick(2, KEY256);
        wait_done(2, 1'b0, 0, 200, took);
        check("drain256 cycles",     128'(took), 128'd61);
        check("count256",            128'(nacc[2]), 128'd15);
        check("lat256 rk14",         128'(first[2][14]), 128'd60);
        check_table(-1);

        // AES-128 with random rk_ready.
        kick(0, KEY128);
        wait_done(0, 1'b1, 0, 3000, took);
        check("count128 bp", 128'(nacc[0]), 128'd11);
        check_table(0);

`ifdef AES_KEYEXP_STORE_EN
        check("store_valid set", 128'(sv0), 128'd1);
        rd_idx0 = 4'd10;
        @(posedge clk); #1;
        check("store rd10", rd_data0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd_idx0 = 4'd12;
        @(posedge clk); #1;
        check("store rd12", rd_data0, 128'd0);
        rd_idx0 = 4'd1;
        @(posedge clk); #1;
        check("store rd1", rd_data0, 128'ha0fafe1788542cb123a339392a6c7605);
        kick(0, KEY128);
        check("store_valid cleared", 128'(sv0), 128'd0);
        wait_done(0, 1'b0, 0, 200, took);
        check("store_valid again", 128'(sv0), 128'd1);
`endif

        // AES-256 aborted by reset at word 20, then a clean run with a start poke while busy.
        kick(2, KEY256);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort busy",        128'(busy2), 128'd0);
        check("abort rk_valid",    128'(if256.rk_valid), 128'd0);
        check("abort rk_idx",      128'(if256.rk_idx), 128'd0);
        check("abort start_ready", 128'(if256.start_ready), 128'd1);
        kick(2, KEY256);
        wait_done(2, 1'b0, 3, 200, took);
        check("rerun256 cycles", 128'(took), 128'd61);
        check("rerun256 count",  128'(nacc[2]), 128'd15);
        check_table(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
